// File: rtl/usbf_dma_arb_if.sv
// Handshake bundle between the DMA arbiter, the endpoint register files
// and the system DMA channel.
interface usbf_dma_arb_if #(
  parameter int NUM_EP = 16
) ();
  logic [NUM_EP-1:0] dma_req;
  logic [NUM_EP-1:0] ep_en;
  logic [NUM_EP-1:0] dma_ack;
  logic              sys_req;
  logic              sys_ack;
  logic [3:0]        sys_ep;
  logic              busy;
  logic              err;
  logic              err_clr;

  modport master (
    input  dma_req, ep_en, sys_ack, err_clr,
    output dma_ack, sys_req, sys_ep, busy, err
  );

  modport slave (
    output dma_req, ep_en, sys_ack, err_clr,
    input  dma_ack, sys_req, sys_ep, busy, err
  );
endinterface

// File: rtl/usbf_dma_arb.sv
// usbf_dma_arb: round-robin DMA request arbiter for USB function endpoints.
// Define USBF_DMA_ARB_TIMEOUT_EN for the XFER watchdog and sticky err flag.
module usbf_dma_arb #(
  parameter int NUM_EP    = 16,
  parameter int BURST_LEN = 4
) (
  input logic            clk,
  input logic            rst,
  usbf_dma_arb_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    XFER,
    GAP1,
    GAP2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        grant_q, grant_d;
  logic [3:0]        last_q, last_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [NUM_EP-1:0] ack_q, ack_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;

  logic [15:0] req_v;
  logic [15:0] one_hot;
  logic [3:0]  pick;
  logic [3:0]  idx;
  logic        found;
  logic        tmo;

  assign req_v   = 16'(bus.dma_req & bus.ep_en);
  assign one_hot = 16'd1 << grant_q;

  // Rotating priority: first enabled request after the last grant.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    idx   = last_q;
    for (int i = 1; i <= NUM_EP; i++) begin
      idx = 4'((int'(last_q) + i) % NUM_EP);
      if (!found && req_v[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

`ifdef USBF_DMA_ARB_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;

  assign tmo   = (state_q == XFER) && !bus.sys_ack
               && (wd_q == 8'd254);
  assign wd_d  = (state_q == XFER) ? wd_q + 8'd1 : 8'd0;
  assign err_d = tmo | (err_q & ~bus.err_clr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= 8'd0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_err_clr;

  assign tmo            = 1'b0;
  assign unused_err_clr = bus.err_clr;
  assign bus.err        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (|req_v) state_d = ARB;
      end
      ARB: begin
        if (found) begin
          grant_d = pick;
          last_d  = pick;
          cnt_d   = 8'd0;
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (tmo) begin
          state_d = IDLE;
        end else if (bus.sys_ack) begin
          ack_d   = one_hot[NUM_EP-1:0];
          cnt_d   = cnt_q + 8'd1;
          state_d = GAP1;
        end
      end
      GAP1: state_d = GAP2;
      GAP2: begin
        if (req_v[grant_q] && (cnt_q < 8'(BURST_LEN)))
          state_d = XFER;
        else
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_d  = (state_d == XFER);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 4'd0;
      last_q  <= 4'(NUM_EP - 1);
      cnt_q   <= 8'd0;
      ack_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.dma_ack = ack_q;
  assign bus.sys_req = req_q;
  assign bus.sys_ep  = grant_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_usbf_dma_arb.sv
// Self-checking bench for usbf_dma_arb: table-driven round-robin
// scoreboard plus hand-written timing, reset, release and masking cases.
module tb_usbf_dma_arb;
  localparam int NEP = 16;
  localparam int BL  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  usbf_dma_arb_if #(.NUM_EP(NEP)) bus ();

  usbf_dma_arb #(.NUM_EP(NEP), .BURST_LEN(BL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  bit   auto_ack = 1'b0;
  bit   mon_en   = 1'b0;
  logic a_ack    = 1'b0;
  logic m_ack    = 1'b0;
  assign bus.sys_ack = auto_ack ? a_ack : m_ack;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] req;
    logic [15:0] en;
    int          words;
  } vec_t;

  vec_t vecs[4];
  int   exp_q[$];
  int   mdl_last;
  int   mdl_left;

  function automatic int next_ep(input logic [15:0] m, input int last);
    int k;
    for (int i = 1; i <= NEP; i++) begin
      k = (last + i) % NEP;
      if (m[k[3:0]]) return k;
    end
    return -1;
  endfunction

  task automatic wait_req();
    int c;
    c = 0;
    while (!bus.sys_req && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("sys_req_wait", 32'(bus.sys_req), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (bus.busy && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 32'(bus.busy), 32'd0);
  endtask

  // Responder: acknowledges in the same cycle sys_req is seen.
  initial forever begin
    @(negedge clk);
    a_ack = bus.sys_req;
  end

  initial begin : mon
    int          e;
    logic [15:0] one;
    forever begin
      @(negedge clk);
      if (mon_en && bus.dma_ack != '0) begin
        if (exp_q.size() == 0) begin
          chk("ack_extra", 32'(bus.dma_ack), 32'd0);
        end else begin
          e   = exp_q.pop_front();
          one = 16'd1 << e;
          chk("ack_ep", 32'(bus.dma_ack), 32'(one));
          chk("ack_sys_ep", 32'(bus.sys_ep), 32'(e));
        end
      end
    end
  end

  initial begin : main
    int          cnt;
    logic [15:0] acc;
    int          nacks;

    vecs[0] = '{16'h0004, 16'hFFFF, 8};
    vecs[1] = '{16'h0003, 16'h0002, 8};
    vecs[2] = '{16'hFFFF, 16'h0421, 12};
    vecs[3] = '{16'h8003, 16'hFFFF, 20};

    bus.dma_req = '0;
    bus.ep_en   = '0;
    bus.err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sys_req", 32'(bus.sys_req), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_dma_ack", 32'(bus.dma_ack), 32'd0);
    chk("rst_sys_ep", 32'(bus.sys_ep), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    mon_en   = 1'b1;
    auto_ack = 1'b1;
    mdl_last = NEP - 1;
    for (int v = 0; v < 4; v++) begin
      mdl_left = 0;
      for (int w = 0; w < vecs[v].words; w++) begin
        if (mdl_left == 0) begin
          mdl_last = next_ep(vecs[v].req & vecs[v].en, mdl_last);
          mdl_left = BL;
        end
        exp_q.push_back(mdl_last);
        mdl_left--;
      end
      @(negedge clk);
      bus.dma_req = vecs[v].req;
      bus.ep_en   = vecs[v].en;
      for (int c = 0; c < 400 && exp_q.size() != 0; c++)
        @(negedge clk);
      chk($sformatf("vec%0d_drain", v), 32'(exp_q.size()), 32'd0);
      bus.dma_req = '0;
      exp_q.delete();
      repeat (6) @(negedge clk);
      chk($sformatf("vec%0d_idle", v), 32'(bus.busy), 32'd0);
    end
    mon_en   = 1'b0;
    auto_ack = 1'b0;

    // Single requester timing with a manual sys_ack
    @(negedge clk);
    bus.dma_req = 16'h0004;
    bus.ep_en   = 16'hFFFF;
    @(posedge clk); #1;
    chk("arb_busy", 32'(bus.busy), 32'd1);
    chk("arb_sys_req", 32'(bus.sys_req), 32'd0);
    @(posedge clk); #1;
    chk("xfer_sys_req", 32'(bus.sys_req), 32'd1);
    chk("xfer_sys_ep", 32'(bus.sys_ep), 32'd2);
    for (int w = 0; w < BL; w++) begin
      @(negedge clk);
      m_ack = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("w%0d_dma_ack", w), 32'(bus.dma_ack), 32'h4);
      chk($sformatf("w%0d_gap1_req", w), 32'(bus.sys_req), 32'd0);
      @(negedge clk);
      m_ack = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("w%0d_gap2_ack", w), 32'(bus.dma_ack), 32'd0);
      @(posedge clk); #1;
      if (w < BL - 1)
        chk($sformatf("w%0d_resume", w), 32'(bus.sys_req), 32'd1);
      else
        chk("burst_end_idle", 32'(bus.busy), 32'd0);
    end
    @(posedge clk); #1;
    chk("rearb_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    chk("regrant_req", 32'(bus.sys_req), 32'd1);
    chk("regrant_ep", 32'(bus.sys_ep), 32'd2);

    // Asynchronous reset in the middle of XFER
    #2;
    rst = 1'b0;
    #1;
    chk("arst_sys_req", 32'(bus.sys_req), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_dma_ack", 32'(bus.dma_ack), 32'd0);
    @(negedge clk);
    bus.dma_req = 16'hFFFF;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_arb", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    chk("post_rst_req", 32'(bus.sys_req), 32'd1);
    chk("post_rst_ep0", 32'(bus.sys_ep), 32'd0);
    bus.dma_req = '0;
    auto_ack = 1'b1;
    wait_idle("post_rst_idle");
    auto_ack = 1'b0;

    // Early release by endpoint 5
    @(negedge clk);
    bus.dma_req = 16'h0020;
    wait_req();
    chk("rel_sys_ep", 32'(bus.sys_ep), 32'd5);
    @(negedge clk);
    m_ack = 1'b1;
    @(posedge clk); #1;
    chk("rel_dma_ack", 32'(bus.dma_ack), 32'h20);
    @(negedge clk);
    m_ack = 1'b0;
    bus.dma_req = '0;
    @(posedge clk); #1;
    chk("rel_gap2_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    chk("rel_idle_busy", 32'(bus.busy), 32'd0);
    nacks = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.dma_ack != '0 || bus.sys_req) nacks++;
    end
    chk("rel_quiet", 32'(nacks), 32'd0);

    // sys_ack in IDLE is ignored; ep_en masks endpoint 0
    @(negedge clk);
    m_ack = 1'b1;
    @(posedge clk); #1;
    chk("idle_ack_dma", 32'(bus.dma_ack), 32'd0);
    chk("idle_ack_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    m_ack = 1'b0;
    bus.dma_req = 16'h0003;
    bus.ep_en   = 16'h0002;
    auto_ack    = 1'b1;
    acc   = '0;
    nacks = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.dma_ack != '0) begin
        acc = acc | bus.dma_ack;
        nacks++;
      end
    end
    chk("mask_acc", 32'(acc), 32'h2);
    chk("mask_seen", 32'(nacks > 4), 32'd1);
    bus.dma_req = '0;
    bus.ep_en   = 16'hFFFF;
    wait_idle("mask_idle");
    auto_ack = 1'b0;

    // Stalled word on endpoint 3
    @(negedge clk);
    m_ack = 1'b0;
    bus.dma_req = 16'h0008;
    wait_req();
    chk("stall_ep", 32'(bus.sys_ep), 32'd3);
    cnt = 0;
    acc = '0;
    while (bus.sys_req && cnt < 300) begin
      cnt++;
      @(posedge clk); #1;
      acc = acc | bus.dma_ack;
    end
`ifdef USBF_DMA_ARB_TIMEOUT_EN
    bus.dma_req = '0;
    chk("tmo_cycles", 32'(cnt), 32'd255);
    chk("tmo_err", 32'(bus.err), 32'd1);
    chk("tmo_no_ack", 32'(acc), 32'd0);
    chk("tmo_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    chk("err_clr", 32'(bus.err), 32'd0);
    bus.err_clr = 1'b0;
`else
    chk("stall_cycles", 32'(cnt), 32'd300);
    chk("stall_err", 32'(bus.err), 32'd0);
    chk("stall_no_ack", 32'(acc), 32'd0);
    bus.dma_req = '0;
    @(negedge clk);
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    wait_idle("stall_idle");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
